// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/execute FSM with a single accumulator, C/Z flags,
// a hardware return stack, an output port and a req/ack data-memory interface.
module acc_cpu_core #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   prog_addr,
    input  logic [ADDR_W+3:0]   prog_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                out_valid,
    output logic                halted,
    output logic                stack_err
);

    localparam int PW   = 4 + ADDR_W;
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LD    = 4'h2;
    localparam logic [3:0] OP_ST    = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h6;
    localparam logic [3:0] OP_CMPI  = 4'h7;
    localparam logic [3:0] OP_NANDI = 4'h8;
    localparam logic [3:0] OP_IN    = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_JNZ   = 4'hD;
    localparam logic [3:0] OP_CALL  = 4'hE;
    localparam logic [3:0] OP_RET   = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEMWAIT, S_HALT} state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_next;
    logic [PW-1:0]       r_ir, w_ir_next;
    logic [DATA_W-1:0]   r_a, w_a_next;
    logic                r_c, w_c_next;
    logic                r_z, w_z_next;
    logic [SPW-1:0]      r_sp, w_sp_next;
    logic [DATA_W-1:0]   r_out_port, w_out_port_next;
    logic                r_out_valid, w_out_valid_next;
    logic                r_stack_err, w_stack_err_next;
    logic                w_push;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_f;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_operand;
    logic [DATA_W:0]     w_add;
    logic [DATA_W:0]     w_sub;
    logic [DATA_W-1:0]   w_nand;
    logic [IDXW-1:0]     w_push_idx;
    logic [IDXW-1:0]     w_ret_idx;

    assign w_op       = r_ir[PW-1:ADDR_W];
    assign w_f        = r_ir[ADDR_W-1:0];
    assign w_imm      = r_ir[DATA_W-1:0];
    // ADD shares the adder with ADDI; its operand arrives from memory on the ack cycle.
    assign w_operand  = (r_state == S_MEMWAIT) ? mem_rdata : w_imm;
    assign w_add      = {1'b0, r_a} + {1'b0, w_operand};
    assign w_sub      = {1'b0, r_a} - {1'b0, w_imm};
    assign w_nand     = ~(r_a & w_imm);
    assign w_push_idx = IDXW'(r_sp);
    assign w_ret_idx  = IDXW'(r_sp - SPW'(1));

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_ir_next        = r_ir;
        w_a_next         = r_a;
        w_c_next         = r_c;
        w_z_next         = r_z;
        w_sp_next        = r_sp;
        w_out_port_next  = r_out_port;
        w_out_valid_next = 1'b0;
        w_stack_err_next = r_stack_err;
        w_push           = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_next    = prog_data;
                w_pc_next    = r_pc + ADDR_W'(1);
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                case (w_op)
                    OP_NOP: begin
                        if (w_f != '0) w_state_next = S_HALT;
                    end
                    OP_LDI: begin
                        w_a_next = w_imm;
                        w_z_next = (w_imm == '0);
                    end
                    OP_LD, OP_ST, OP_ADD: w_state_next = S_MEMWAIT;
                    OP_ADDI: begin
                        w_a_next = w_add[DATA_W-1:0];
                        w_c_next = w_add[DATA_W];
                        w_z_next = (w_add[DATA_W-1:0] == '0);
                    end
                    OP_SUBI: begin
                        w_a_next = w_sub[DATA_W-1:0];
                        w_c_next = ~w_sub[DATA_W];
                        w_z_next = (w_sub[DATA_W-1:0] == '0);
                    end
                    OP_CMPI: begin
                        w_c_next = ~w_sub[DATA_W];
                        w_z_next = (w_sub[DATA_W-1:0] == '0);
                    end
                    OP_NANDI: begin
                        w_a_next = w_nand;
                        w_c_next = 1'b0;
                        w_z_next = (w_nand == '0);
                    end
                    OP_IN: begin
                        w_a_next = in_port;
                        w_z_next = (in_port == '0);
                    end
                    OP_OUT: begin
                        w_out_port_next  = r_a;
                        w_out_valid_next = 1'b1;
                    end
                    OP_JMP: w_pc_next = w_f;
                    OP_JC: begin
                        if (r_c) w_pc_next = w_f;
                    end
                    OP_JNZ: begin
                        if (!r_z) w_pc_next = w_f;
                    end
                    OP_CALL: begin
                        if (r_sp == SP_FULL) begin
                            w_stack_err_next = 1'b1;
                            w_state_next     = S_HALT;
                        end else begin
                            w_push    = 1'b1;
                            w_sp_next = r_sp + SPW'(1);
                            w_pc_next = w_f;
                        end
                    end
                    OP_RET: begin
                        if (r_sp == '0) begin
                            w_stack_err_next = 1'b1;
                            w_state_next     = S_HALT;
                        end else begin
                            w_sp_next = r_sp - SPW'(1);
                            w_pc_next = r_stack[w_ret_idx];
                        end
                    end
                    default: ;
                endcase
            end
            S_MEMWAIT: begin
                if (mem_ack) begin
                    w_state_next = S_FETCH;
                    if (w_op == OP_LD) begin
                        w_a_next = mem_rdata;
                        w_z_next = (mem_rdata == '0);
                    end else if (w_op == OP_ADD) begin
                        w_a_next = w_add[DATA_W-1:0];
                        w_c_next = w_add[DATA_W];
                        w_z_next = (w_add[DATA_W-1:0] == '0);
                    end
                end
            end
            S_HALT: ;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_sp        <= '0;
            r_out_port  <= '0;
            r_out_valid <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_ir        <= w_ir_next;
            r_a         <= w_a_next;
            r_c         <= w_c_next;
            r_z         <= w_z_next;
            r_sp        <= w_sp_next;
            r_out_port  <= w_out_port_next;
            r_out_valid <= w_out_valid_next;
            r_stack_err <= w_stack_err_next;
        end
    end

    // Return stack holds no reset state; SP alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) r_stack[w_push_idx] <= r_pc;
    end

    assign prog_addr = r_pc;
    assign mem_req   = (r_state == S_MEMWAIT);
    assign mem_we    = (w_op == OP_ST);
    assign mem_addr  = w_f;
    assign mem_wdata = r_a;
    assign out_port  = r_out_port;
    assign out_valid = r_out_valid;
    assign halted    = (r_state == S_HALT);
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: small programs in a modelled ROM, a
// delayed-ack data memory, and scoreboards for OUT values and memory writes.
module tb_acc_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata = 4'h0;
    logic        mem_ack = 1'b0;
    logic [3:0]  in_port = 4'h0;
    logic [3:0]  out_port;
    logic        out_valid;
    logic        halted;
    logic        stack_err;

    acc_cpu_core #(.DATA_W(4), .ADDR_W(12), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_valid (out_valid),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom  [0:4095];
    logic [3:0]  dmem [0:4095];
    assign prog_data = rom[prog_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_dly = 0;

    logic [3:0]  exp_out [$];
    logic [15:0] exp_wr  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] f);
        return {op, f};
    endfunction

    // Output monitor plus data-memory responder with a programmable ack delay.
    int          wait_cnt = 0;
    int          req_run  = 0;
    logic        prev_ov  = 1'b0;
    logic        prev_ack = 1'b0;
    logic [11:0] stall_pc = '0;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            $display("[TB] out_port=0x%0h", out_port);
            if (exp_out.size() == 0) check_eq("out_extra", exp_out.size(), 1);
            else check_eq("out_port", {28'b0, out_port}, {28'b0, exp_out.pop_front()});
            check_eq("ov_pulse", {31'b0, prev_ov}, 0);
        end
        prev_ov = out_valid;
        if (rst_n && prev_ack) check_eq("req_drop", {31'b0, mem_req}, 0);
        prev_ack = 1'b0;
        if (mem_req) begin
            if (req_run == 0) stall_pc = prog_addr;
            req_run++;
            if (wait_cnt == ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = dmem[mem_addr];
                prev_ack  = 1'b1;
                wait_cnt  = 0;
                if (rst_n) begin
                    $display("[TB] mem %s addr=0x%03h data=0x%0h", mem_we ? "wr" : "rd",
                             mem_addr, mem_we ? mem_wdata : dmem[mem_addr]);
                    check_eq("req_len", req_run, ack_dly + 1);
                    check_eq("pc_stall", {20'b0, prog_addr}, {20'b0, stall_pc});
                    if (mem_we) begin
                        if (exp_wr.size() == 0) check_eq("wr_extra", exp_wr.size(), 1);
                        else check_eq("mem_write", {16'b0, mem_addr, mem_wdata},
                                      {16'b0, exp_wr.pop_front()});
                    end
                end
                if (mem_we) dmem[mem_addr] = mem_wdata;
                req_run = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            req_run  = 0;
        end
    end

    task automatic rom_clear();
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0001;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pc",     {20'b0, prog_addr}, 0);
        check_eq("rst_req",    {31'b0, mem_req}, 0);
        check_eq("rst_halted", {31'b0, halted}, 0);
        check_eq("rst_serr",   {31'b0, stack_err}, 0);
        check_eq("rst_ov",     {31'b0, out_valid}, 0);
        check_eq("rst_out",    {28'b0, out_port}, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int max_cyc);
        int n = 0;
        while (!halted && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("halt_reached", {31'b0, halted}, 1);
    endtask

    task automatic finish_prog(input string name, input logic [11:0] pc, input logic serr);
        run_until_halt(400);
        check_eq({name, "_pc"},   {20'b0, prog_addr}, {20'b0, pc});
        check_eq({name, "_serr"}, {31'b0, stack_err}, {31'b0, serr});
        check_eq({name, "_outq"}, exp_out.size(), 0);
        check_eq({name, "_wrq"},  exp_wr.size(), 0);
        $display("[TB] program %s done pc=0x%03h", name, prog_addr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // LDI/ADDI timing, carry out, then flags observed through JC/JNZ.
        rom_clear();
        rom[0] = ins(4'h1, 12'h005); rom[1] = ins(4'h4, 12'h00C); rom[2] = ins(4'h0, 12'h000);
        rom[3] = ins(4'hA, 12'h000); rom[4] = ins(4'hC, 12'h020);
        rom[12'h020] = ins(4'hD, 12'h030);
        exp_out.push_back(4'h1);
        reset_dut();
        repeat (2) @(posedge clk);
        #1 check_eq("pc_c2", {20'b0, prog_addr}, 1);
        repeat (2) @(posedge clk);
        #1 check_eq("pc_c4", {20'b0, prog_addr}, 2);
        finish_prog("addi", 12'h031, 1'b0);

        // SUBI borrow (C=0), NANDI giving zero (Z=1, C=0).
        rom_clear();
        rom[0] = ins(4'h1, 12'h002); rom[1] = ins(4'h6, 12'h003); rom[2] = ins(4'hA, 12'h000);
        rom[3] = ins(4'hC, 12'h050); rom[4] = ins(4'hD, 12'h008);
        rom[5] = 16'h0000; rom[6] = 16'h0000; rom[7] = 16'h0000;
        rom[8] = ins(4'h8, 12'h00F); rom[9] = ins(4'hA, 12'h000); rom[10] = ins(4'hD, 12'h050);
        exp_out.push_back(4'hF); exp_out.push_back(4'h0);
        reset_dut();
        finish_prog("subnand", 12'h00C, 1'b0);

        // Memory access with 3-cycle ack delay: ST, LD, ADD from memory.
        ack_dly = 3;
        rom_clear();
        rom[0] = ins(4'h1, 12'h007); rom[1] = ins(4'h3, 12'h010); rom[2] = ins(4'h1, 12'h000);
        rom[3] = ins(4'h2, 12'h010); rom[4] = ins(4'hA, 12'h000); rom[5] = ins(4'h1, 12'h00A);
        rom[6] = ins(4'h3, 12'h011); rom[7] = ins(4'h2, 12'h010); rom[8] = ins(4'h5, 12'h011);
        rom[9] = ins(4'hA, 12'h000); rom[10] = ins(4'hC, 12'h040);
        exp_wr.push_back({12'h010, 4'h7}); exp_wr.push_back({12'h011, 4'hA});
        exp_out.push_back(4'h7); exp_out.push_back(4'h1);
        reset_dut();
        finish_prog("mem", 12'h041, 1'b0);
        ack_dly = 0;

        // CMPI equal: Z=1, C=1, A unchanged; JNZ falls through, JC taken.
        rom_clear();
        rom[0] = ins(4'h1, 12'h003); rom[1] = ins(4'h7, 12'h003); rom[2] = ins(4'hD, 12'h000);
        rom[3] = ins(4'hC, 12'h020); rom[12'h020] = ins(4'hA, 12'h000);
        exp_out.push_back(4'h3);
        reset_dut();
        finish_prog("cmpi", 12'h022, 1'b0);

        // Nested CALL/RET returning correctly.
        rom_clear();
        rom[0] = ins(4'hE, 12'h010); rom[1] = ins(4'hA, 12'h000);
        rom[12'h010] = ins(4'h1, 12'h006); rom[12'h011] = ins(4'hE, 12'h020);
        rom[12'h012] = ins(4'hF, 12'h000); rom[12'h020] = ins(4'hF, 12'h000);
        exp_out.push_back(4'h6);
        reset_dut();
        finish_prog("callret", 12'h003, 1'b0);

        // Five nested CALLs overflow a 4-deep stack; PC stays frozen afterwards.
        rom_clear();
        for (int i = 0; i < 5; i++) rom[i * 256] = ins(4'hE, 12'((i + 1) * 256));
        reset_dut();
        finish_prog("overflow", 12'h401, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("ovf_frozen_pc", {20'b0, prog_addr}, 12'h401);
        check_eq("ovf_still_halted", {31'b0, halted}, 1);
        check_eq("ovf_no_req", {31'b0, mem_req}, 0);

        // RET straight out of reset underflows.
        rom_clear();
        rom[0] = ins(4'hF, 12'h000);
        reset_dut();
        finish_prog("underflow", 12'h001, 1'b1);

        // IN non-zero then OUT; IN zero sets Z.
        in_port = 4'h9;
        rom_clear();
        rom[0] = ins(4'h9, 12'h000); rom[1] = ins(4'hA, 12'h000); rom[2] = ins(4'hD, 12'h010);
        exp_out.push_back(4'h9);
        reset_dut();
        finish_prog("in9", 12'h011, 1'b0);
        in_port = 4'h0;
        rom_clear();
        rom[0] = ins(4'h1, 12'h005); rom[1] = ins(4'h9, 12'h000); rom[2] = ins(4'hA, 12'h000);
        rom[3] = ins(4'hD, 12'h010);
        exp_out.push_back(4'h0);
        reset_dut();
        finish_prog("in0", 12'h005, 1'b0);

        // Reset while stalled in MEMWAIT.
        ack_dly = 10;
        rom_clear();
        rom[0] = ins(4'h2, 12'h010);
        reset_dut();
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check_eq("memwait_seen", {31'b0, mem_req}, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mwrst_req", {31'b0, mem_req}, 0);
        check_eq("mwrst_pc",  {20'b0, prog_addr}, 0);
        check_eq("mwrst_halted", {31'b0, halted}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mwrel_pc0", {20'b0, prog_addr}, 0);
        @(posedge clk);
        #1 check_eq("mwrel_pc1", {20'b0, prog_addr}, 1);
        rom[0] = ins(4'h0, 12'h001);
        reset_dut();
        ack_dly = 0;
        run_until_halt(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
